rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8_if.sv | 28 ++
 rtl/rr_arbiter8.sv | 107 ++++++++++
 tb/tb_rr_arbiter8.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the rr_arbiter8 block.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output busy
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, a tenure limit
// and one dead cycle between consecutive grants.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter8_if.slave     bus
);

  localparam int                 CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]   HOLD_LIM = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [2:0] win;
  logic       any_req;
  logic       release_now;

  // First requester found when scanning ptr, ptr+1, ... with modulo-8 wrap.
  function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    logic [2:0] idx;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    win         = 3'd0;
    any_req     = 1'b0;
    release_now = 1'b0;
    win         = pick_winner(bus.req, ptr);
    any_req     = |bus.req;
    release_now = bus.done || !bus.req[bus.gnt_idx] || (hold_cnt == HOLD_LIM);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      hold_cnt      <= '0;
      bus.gnt       <= 8'h00;
      bus.gnt_idx   <= 3'd0;
      bus.gnt_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, RELEASE: begin
          // Requests raised while a grant was held are first seen here.
          if (any_req) begin
            state         <= GRANT;
            bus.gnt_idx   <= win;
            bus.gnt       <= 8'h01 << win;
            bus.gnt_valid <= 1'b1;
            bus.busy      <= 1'b1;
            hold_cnt      <= CNT_W'(1);
          end else begin
            state         <= IDLE;
            bus.gnt       <= 8'h00;
            bus.gnt_valid <= 1'b0;
            bus.busy      <= 1'b0;
            hold_cnt      <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state         <= RELEASE;
            ptr           <= bus.gnt_idx + 3'd1;
            bus.gnt       <= 8'h00;
            bus.gnt_valid <= 1'b0;
            bus.busy      <= 1'b1;
            hold_cnt      <= '0;
          end else begin
            hold_cnt      <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state         <= IDLE;
          bus.gnt       <= 8'h00;
          bus.gnt_valid <= 1'b0;
          bus.busy      <= 1'b0;
          hold_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized and directed bench for rr_arbiter8: a request-level reference
// model predicts each cycle's grant; a separate monitor compares the DUT.
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference model: who owns the resource, for how long, and where the
  // next search begins.
  int  m_owner;
  int  m_held;
  int  m_start;
  int  m_last;
  bit  m_dead;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_start = 0;
    m_last  = 0;
    m_dead  = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, output exp_t e);
    int w;
    if (m_owner >= 0) begin
      if (d || !r[m_owner] || m_held == HOLD) begin
        m_start = (m_owner + 1) % 8;
        m_last  = m_owner;
        m_owner = -1;
        m_dead  = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && r[(m_start + k) % 8]) w = (m_start + k) % 8;
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
        m_last  = w;
      end
      m_dead = 1'b0;
    end
    e.valid = (m_owner >= 0);
    e.gnt   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.idx   = 3'(m_last);
    e.busy  = (m_owner >= 0) || m_dead;
  endtask

  // One clock of stimulus: drive away from the edge, predict, enqueue.
  task automatic cycle(input logic [7:0] r, input logic d);
    exp_t e;
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    model_step(r, d, e);
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   bus.gnt, 8'h00);
    check({tag, "_idx"},   {5'd0, bus.gnt_idx}, 8'h00);
    check({tag, "_valid"}, {7'd0, bus.gnt_valid}, 8'h00);
    check({tag, "_busy"},  {7'd0, bus.busy}, 8'h00);
  endtask

  // Monitor: compares DUT outputs 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("gnt",       bus.gnt, e.gnt);
        check("gnt_idx",   {5'd0, bus.gnt_idx}, {5'd0, e.idx});
        check("gnt_valid", {7'd0, bus.gnt_valid}, {7'd0, e.valid});
        check("busy",      {7'd0, bus.busy}, {7'd0, e.busy});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       d;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Single request, release by done; a later 0/5 contention shows ptr=5.
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b1);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h21, 1'b0);
    cycle(8'h21, 1'b1);
    cycle(8'h00, 1'b0);

    // Ignored done in IDLE, then a normal grant.
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b0);
    cycle(8'h02, 1'b0);
    cycle(8'h02, 1'b1);
    cycle(8'h00, 1'b0);

    // Rotation with wrap between 0 and 7.
    for (int i = 0; i < 16; i++) cycle(8'h81, 1'b1);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Tenure limit with two persistent requesters.
    for (int i = 0; i < 22; i++) cycle(8'h06, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Single persistent requester is regranted after the dead cycle.
    for (int i = 0; i < 12; i++) cycle(8'h01, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Simultaneous done and req drop on idx3 with 4 and 5 pending.
    cycle(8'h08, 1'b0);
    cycle(8'h08, 1'b0);
    cycle(8'h30, 1'b1);
    cycle(8'h30, 1'b0);
    cycle(8'h30, 1'b0);
    cycle(8'h30, 1'b1);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Randomized traffic.
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) r = 8'($urandom) & 8'($urandom);
      d = ($urandom_range(0, 3) == 0);
      cycle(r, d);
    end
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Asynchronous reset while requester 6 holds the grant.
    cycle(8'h40, 1'b0);
    cycle(8'h40, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = 8'h00;
    cycle(8'hFF, 1'b0);
    cycle(8'hFF, 1'b1);
    cycle(8'hFF, 1'b0);
    cycle(8'hFF, 1'b1);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
